// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-snooping UART transmitter for the dual-issue core.
// Stores to UART_ADDR from either M-stage slot enqueue a byte into a small
// FIFO; an 8N1 serializer drains the FIFO onto uart_tx. A status word
// {overflow, fifo_full, tx_busy} is offered combinationally for loads.
//
// Push handshake: each store slot acts as a valid with no ready. A push is
// accepted whenever the FIFO has room at that edge (counting a same-cycle
// pop). Otherwise the byte is dropped and the sticky overflow flag records
// the loss. A store to STATUS_ADDR clears overflow, winning over a same-cycle
// set.
module mmio_uart_tx #(
    parameter logic [31:0] UART_ADDR   = 32'h0000_FF00,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_FF04,
    parameter int          CLK_DIV     = 868,
    parameter int          FIFO_AW     = 4
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [31:0] resultM1,
    input  logic [31:0] resultM2,
    input  logic [31:0] Source1,
    input  logic [31:0] Source2,
    input  logic [1:0]  mem_store1,
    input  logic [1:0]  mem_store2,
    output logic [31:0] status_data,
    output logic        uart_tx,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam int               BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_W   = (FIFO_AW + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_addr2;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [FIFO_AW:0]   free;
    logic               ovf_q, ovf_d;
    logic               push1, push2, clr_ovf;
    logic               acc1, acc2, ovf_set;
    logic               pop;
    logic               baud_end;
    logic               fifo_empty, fifo_full, tx_busy;
    logic               unused_hi_bytes;

    // Only the low byte of store data is transmitted.
    assign unused_hi_bytes = ^{Source1[31:8], Source2[31:8]};

    assign push1    = (mem_store1 != 2'b00) && (resultM1 == UART_ADDR);
    assign push2    = (mem_store2 != 2'b00) && (resultM2 == UART_ADDR);
    assign clr_ovf  = ((mem_store1 != 2'b00) && (resultM1 == STATUS_ADDR)) ||
                      ((mem_store2 != 2'b00) && (resultM2 == STATUS_ADDR));

    assign baud_end   = (baud_q == BAUD_LAST);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_W);
    assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;

    assign status_data = {29'd0, ovf_q, fifo_full, tx_busy};
    assign uart_tx     = tx_q;
    assign dbg_state_o = state_q;

    // Serializer next state: pops the FIFO head in IDLE or at the last STOP
    // cycle; the line value is registered from the current state, so it
    // trails the state by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d   = 1'b0;
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                tx_d   = shift_q[idx_q];
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                tx_d   = 1'b1;
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: slot 1 is older and claims free space first; a pop in
    // the same cycle frees its slot for the incoming pushes.
    always_comb begin
        free     = DEPTH_W - count_q + (FIFO_AW + 1)'(pop);
        acc1     = push1 && (free != '0);
        acc2     = push2 && ((free - (FIFO_AW + 1)'(acc1)) != '0);
        ovf_set  = (push1 && !acc1) || (push2 && !acc2);
        wr_addr2 = wr_ptr_q + FIFO_AW'(acc1);
        wr_ptr_d = wr_ptr_q + FIFO_AW'(acc1) + FIFO_AW'(acc2);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        count_d  = count_q + (FIFO_AW + 1)'(acc1) + (FIFO_AW + 1)'(acc2)
                   - (FIFO_AW + 1)'(pop);
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and serializer registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; a write into the slot being popped is safe because the
    // pop reads the old contents before this edge.
    always_ff @(posedge CLK) begin
        if (NRST && acc1) begin
            mem_q[wr_ptr_q] <= Source1[7:0];
        end
        if (NRST && acc2) begin
            mem_q[wr_addr2] <= Source2[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with a 4-cycle bit time and a 4-deep FIFO.
// A transaction-level model (byte queue, frame timer, expected line queue)
// predicts uart_tx and status_data every cycle; table vectors and directed
// sequences add fixed expectations for the corner cases.
module tb_mmio_uart_tx;

    localparam int          CLK_DIV = 4;
    localparam int          FIFO_AW = 2;
    localparam int          DEPTH   = 4;
    localparam int          FRAME   = 10 * CLK_DIV;
    localparam logic [31:0] UART    = 32'h0000_FF00;
    localparam logic [31:0] STATUS  = 32'h0000_FF04;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic [31:0] resultM1 = UART, resultM2 = UART;
    logic [31:0] Source1 = '0, Source2 = '0;
    logic [1:0]  mem_store1 = 2'b00, mem_store2 = 2'b00;
    logic [31:0] status_data;
    logic        uart_tx;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    mmio_uart_tx #(
        .UART_ADDR(UART), .STATUS_ADDR(STATUS), .CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)
    ) dut (
        .CLK(CLK), .NRST(NRST),
        .resultM1(resultM1), .resultM2(resultM2),
        .Source1(Source1), .Source2(Source2),
        .mem_store1(mem_store1), .mem_store2(mem_store2),
        .status_data(status_data), .uart_tx(uart_tx), .dbg_state_o(dbg_state)
    );

    // ---------------- reference model ----------------
    logic [7:0]  exp_q[$];
    bit          line_q[$];
    int          busy_left = 0;
    bit          m_ovf = 1'b0;
    logic        exp_tx = 1'b1;
    logic [31:0] exp_status = '0;

    always @(posedge CLK) begin : model
        bit         m_pop;
        bit         set_ovf;
        bit         lb;
        logic [7:0] b;
        if (!NRST) begin
            exp_q.delete();
            line_q.delete();
            busy_left = 0;
            m_ovf     = 1'b0;
            exp_tx    = 1'b1;
        end else begin
            exp_tx = (line_q.size() != 0) ? line_q.pop_front() : 1'b1;
            m_pop  = (exp_q.size() != 0) && (busy_left <= 1);
            if (m_pop) begin
                b = exp_q.pop_front();
                for (int j = 0; j < 10; j++) begin
                    if (j == 0) lb = 1'b0;
                    else if (j == 9) lb = 1'b1;
                    else lb = b[j-1];
                    repeat (CLK_DIV) line_q.push_back(lb);
                end
                busy_left = FRAME;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
            end
            set_ovf = 1'b0;
            if (mem_store1 != 2'b00 && resultM1 == UART) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(Source1[7:0]);
                else set_ovf = 1'b1;
            end
            if (mem_store2 != 2'b00 && resultM2 == UART) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(Source2[7:0]);
                else set_ovf = 1'b1;
            end
            if ((mem_store1 != 2'b00 && resultM1 == STATUS) ||
                (mem_store2 != 2'b00 && resultM2 == STATUS)) m_ovf = 1'b0;
            else if (set_ovf) m_ovf = 1'b1;
        end
        exp_status = {29'd0, m_ovf, (exp_q.size() == DEPTH), (busy_left != 0 || exp_q.size() != 0)};
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("mon_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
            check("mon_status", status_data, exp_status);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        mem_store1 = 2'b00; mem_store2 = 2'b00;
        resultM1 = UART;    resultM2 = UART;
        Source1 = $urandom(); Source2 = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic do_reset();
        set_idle();
        NRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 NRST = 1'b1;
    endtask

    task automatic cyc_store(input logic [1:0] st1, input logic [31:0] a1, input logic [31:0] d1,
                             input logic [1:0] st2, input logic [31:0] a2, input logic [31:0] d2);
        mem_store1 = st1; resultM1 = a1; Source1 = d1;
        mem_store2 = st2; resultM2 = a2; Source2 = d2;
        @(posedge CLK); #1;
        set_idle();
    endtask

    // Line receiver: waits (bounded) for a start bit, samples mid-bit.
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int n;
        n = 0; ok = 1'b0; b = '0;
        @(negedge CLK);
        while (uart_tx !== 1'b0 && n < 200) begin @(negedge CLK); n++; end
        if (uart_tx !== 1'b0) return;
        repeat (CLK_DIV / 2) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            repeat (CLK_DIV) @(negedge CLK);
            b[k] = uart_tx;
        end
        repeat (CLK_DIV) @(negedge CLK);
        ok = (uart_tx === 1'b1);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return UART;
        else if (r < 8) return STATUS;
        else if (r == 8) return 32'h0000_FF08;
        else return $urandom();
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        logic [1:0]  st1; logic [31:0] a1; logic [31:0] d1;
        logic [1:0]  st2; logic [31:0] a2; logic [31:0] d2;
        logic [31:0] exp_status; int exp_n; logic [7:0] exp_b0; logic [7:0] exp_b1;
    } vec_t;

    vec_t       vecs [8];
    logic [9:0] a5_line;
    logic [7:0] c_exp [5];
    logic [7:0] rb;
    bit         rok;
    int         lows;
    int         guard;
    bit         active;

    initial begin
        vecs[0] = '{2'b11, UART, 32'h0000_00A5, 2'b00, UART, 32'h0, 32'h1, 1, 8'hA5, 8'h00};
        vecs[1] = '{2'b01, UART, 32'h0000_0041, 2'b11, UART, 32'h1234_5642, 32'h1, 2, 8'h41, 8'h42};
        vecs[2] = '{2'b11, 32'h0000_FF08, 32'h99, 2'b00, UART, 32'h66, 32'h0, 0, 8'h00, 8'h00};
        vecs[3] = '{2'b00, UART, 32'h77, 2'b11, STATUS, 32'h5, 32'h0, 0, 8'h00, 8'h00};
        vecs[4] = '{2'b00, UART, 32'h0, 2'b10, UART, 32'h0000_BEEF, 32'h1, 1, 8'hEF, 8'h00};
        vecs[5] = '{2'b11, STATUS, 32'h0, 2'b01, UART, 32'hFFFF_FF7E, 32'h1, 1, 8'h7E, 8'h00};
        vecs[6] = '{2'b10, UART, 32'h1234_ABCD, 2'b01, UART, 32'h0000_0080, 32'h1, 2, 8'hCD, 8'h80};
        vecs[7] = '{2'b11, 32'h0000_FF01, 32'h11, 2'b11, 32'h0001_FF00, 32'h22, 32'h0, 0, 8'h00, 8'h00};
        a5_line = 10'b11_0100_1010;
        c_exp[0] = 8'h21; c_exp[1] = 8'h22; c_exp[2] = 8'h23; c_exp[3] = 8'h24; c_exp[4] = 8'h31;

        // Reset state
        do_reset();
        chk_en = 1'b1;
        @(negedge CLK);
        check("reset_status", status_data, 32'h0);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_state", {30'd0, dbg_state}, 32'd0);

        // Single frame timing: push at edge t, fall at t+2, 10 bits, high at t+42
        cyc_store(2'b11, UART, 32'h0000_00A5, 2'b00, UART, 32'h0);
        for (int k = 0; k <= 42; k++) begin
            @(negedge CLK);
            if (k <= 1) check("a_pre_fall", {31'd0, uart_tx}, 32'd1);
            if (k >= 2 && k <= 38 && ((k - 2) % 4) == 0)
                check("a_bit", {31'd0, uart_tx}, {31'd0, a5_line[(k - 2) / 4]});
            if (k == 40) check("a_busy_stop", status_data, 32'h1);
            if (k == 41) check("a_busy_drop", status_data, 32'h0);
            if (k == 42) check("a_line_high", {31'd0, uart_tx}, 32'd1);
        end

        // Table vectors, each from a clean reset
        for (int v = 0; v < 8; v++) begin
            do_reset();
            cyc_store(vecs[v].st1, vecs[v].a1, vecs[v].d1, vecs[v].st2, vecs[v].a2, vecs[v].d2);
            @(negedge CLK);
            check("t_status", status_data, vecs[v].exp_status);
            if (vecs[v].exp_n == 0) begin
                lows = 0;
                repeat (44) begin @(negedge CLK); if (uart_tx !== 1'b1) lows++; end
                check("t_idle_line", lows, 0);
            end
            if (vecs[v].exp_n >= 1) begin
                rx_byte(rb, rok);
                check("t_byte0", {24'd0, rb}, {24'd0, vecs[v].exp_b0});
                check("t_stop0", {31'd0, rok}, 32'd1);
            end
            if (vecs[v].exp_n == 2) begin
                rx_byte(rb, rok);
                check("t_byte1", {24'd0, rb}, {24'd0, vecs[v].exp_b1});
                check("t_stop1", {31'd0, rok}, 32'd1);
            end
            idle(4);
            @(negedge CLK);
            check("t_end_status", status_data, 32'h0);
        end

        // Overflow while a frame is in flight, then pop + dual push when full
        do_reset();
        cyc_store(2'b11, UART, 32'h11, 2'b00, UART, 32'h0);        // edge T0
        idle(2);
        for (int i = 0; i < 5; i++) begin
            cyc_store(2'b01, UART, 32'h21 + i, 2'b00, UART, 32'h0); // edges T0+3..T0+7
            @(negedge CLK);
            if (i == 3) check("b_full_no_ovf", status_data, 32'h3);
        end
        check("b_overflow", status_data, 32'h7);
        cyc_store(2'b11, STATUS, 32'h0, 2'b00, UART, 32'h0);       // edge T0+8
        @(negedge CLK);
        check("b_ovf_clear", status_data, 32'h3);
        idle(32);                                                  // through T0+40
        @(negedge CLK);
        check("c_pre_pop", status_data, 32'h3);
        cyc_store(2'b01, UART, 32'h31, 2'b11, UART, 32'h32);       // edge T0+41, final stop cycle
        @(negedge CLK);
        check("c_pop_dual_push", status_data, 32'h7);
        for (int i = 0; i < 5; i++) begin
            rx_byte(rb, rok);
            check("c_drain_byte", {24'd0, rb}, {24'd0, c_exp[i]});
            check("c_drain_stop", {31'd0, rok}, 32'd1);
        end
        idle(6);
        @(negedge CLK);
        check("c_sticky_ovf", status_data, 32'h4);
        cyc_store(2'b00, UART, 32'h0, 2'b01, STATUS, 32'h0);
        @(negedge CLK);
        check("c_clear_slot2", status_data, 32'h0);

        // Reset in the middle of data bit 3
        cyc_store(2'b11, UART, 32'h77, 2'b00, UART, 32'h0);        // edge T
        idle(18);
        @(negedge CLK);
        check("d_bit3_low", {31'd0, uart_tx}, 32'd0);
        NRST = 1'b0;
        @(posedge CLK); #1;
        NRST = 1'b1;
        @(negedge CLK);
        check("d_reset_tx", {31'd0, uart_tx}, 32'd1);
        check("d_reset_status", status_data, 32'h0);
        idle(3);
        cyc_store(2'b11, UART, 32'h55, 2'b00, UART, 32'h0);
        rx_byte(rb, rok);
        check("d_clean_byte", {24'd0, rb}, 32'h55);
        check("d_clean_stop", {31'd0, rok}, 32'd1);

        // Randomized traffic against the model, alternating bursts and gaps
        for (int i = 0; i < 3000; i++) begin
            active = ((i / 150) % 2) == 0;
            if (active && $urandom_range(0, 99) < 40) mem_store1 = 2'($urandom_range(0, 3));
            else mem_store1 = 2'b00;
            if (active && $urandom_range(0, 99) < 40) mem_store2 = 2'($urandom_range(0, 3));
            else mem_store2 = 2'b00;
            resultM1 = pick_addr();
            resultM2 = pick_addr();
            Source1 = $urandom();
            Source2 = $urandom();
            NRST = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            @(posedge CLK); #1;
        end
        NRST = 1'b1;
        set_idle();

        // Drain, bounded
        guard = 0;
        while ((exp_q.size() != 0 || busy_left != 0) && guard < 3000) begin
            @(posedge CLK); #1;
            guard++;
        end
        check("drain_done", {31'd0, (exp_q.size() == 0 && busy_left == 0)}, 32'd1);
        idle(2);
        @(negedge CLK);
        check("final_status_busy", {31'd0, status_data[0]}, 32'd0);
        check("final_state", {30'd0, dbg_state}, 32'd0);
        check("final_tx", {31'd0, uart_tx}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
